// File: rtl/up_wishbone_classic.sv
// Wishbone classic-cycle slave to uP register bus bridge.
// One byte-addressed Wishbone access becomes one word-addressed uP read or write request.
module up_wishbone_classic #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH = 4,
  localparam int DATA_WIDTH = BUS_WIDTH * 8,
  localparam int ADDR_LSB = $clog2(BUS_WIDTH),
  localparam int UP_ADDR_WIDTH = ADDRESS_WIDTH - ADDR_LSB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_wb_cyc,
  input  logic                     s_wb_stb,
  input  logic                     s_wb_we,
  input  logic [ADDRESS_WIDTH-1:0] s_wb_addr,
  input  logic [DATA_WIDTH-1:0]    s_wb_data_i,
  input  logic [2:0]               s_wb_cti,
  input  logic [1:0]               s_wb_bte,
  input  logic [BUS_WIDTH-1:0]     s_wb_sel,
  output logic                     s_wb_ack,
  output logic [DATA_WIDTH-1:0]    s_wb_data_o,
  output logic                     up_rreq,
  input  logic                     up_rack,
  output logic [UP_ADDR_WIDTH-1:0] up_raddr,
  input  logic [DATA_WIDTH-1:0]    up_rdata,
  output logic                     up_wreq,
  input  logic                     up_wack,
  output logic [UP_ADDR_WIDTH-1:0] up_waddr,
  output logic [DATA_WIDTH-1:0]    up_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Handshake: the uP request stays high, with address/data stable, until the
  // matching ack is sampled high; the request drops on that same edge.
  state_t state;
  logic   aborted;
  logic   wb_req;
  logic   unused_inputs;

  assign wb_req = s_wb_cyc & s_wb_stb;

  // Cycle type, burst type, byte selects and the sub-word address bits play no part.
  assign unused_inputs = ^{s_wb_cti, s_wb_bte, s_wb_sel, s_wb_addr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      aborted     <= 1'b0;
      s_wb_ack    <= 1'b0;
      s_wb_data_o <= '0;
      up_rreq     <= 1'b0;
      up_raddr    <= '0;
      up_wreq     <= 1'b0;
      up_waddr    <= '0;
      up_wdata    <= '0;
    end else begin
      s_wb_ack <= 1'b0;
      case (state)
        IDLE: begin
          aborted <= 1'b0;
          // The ack cycle is skipped so a held strobe cannot relaunch the old access.
          if (wb_req && !s_wb_ack) begin
            if (s_wb_we) begin
              up_waddr <= s_wb_addr[ADDRESS_WIDTH-1:ADDR_LSB];
              up_wdata <= s_wb_data_i;
              up_wreq  <= 1'b1;
              state    <= WRITE;
            end else begin
              up_raddr <= s_wb_addr[ADDRESS_WIDTH-1:ADDR_LSB];
              up_rreq  <= 1'b1;
              state    <= READ;
            end
          end
        end
        WRITE: begin
          if (!wb_req) aborted <= 1'b1;
          if (up_wack) begin
            up_wreq  <= 1'b0;
            s_wb_ack <= wb_req && !aborted;
            state    <= IDLE;
          end
        end
        READ: begin
          if (!wb_req) aborted <= 1'b1;
          if (up_rack) begin
            up_rreq     <= 1'b0;
            s_wb_data_o <= up_rdata;
            s_wb_ack    <= wb_req && !aborted;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_wishbone_classic.sv
// Directed bench for up_wishbone_classic: a Wishbone master driver, a uP responder
// with programmable latency, and request/ack monitors feeding immediate checks.
module tb_up_wishbone_classic;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_wb_cyc = 1'b0;
  logic        s_wb_stb = 1'b0;
  logic        s_wb_we = 1'b0;
  logic [15:0] s_wb_addr = '0;
  logic [31:0] s_wb_data_i = '0;
  logic [2:0]  s_wb_cti = '0;
  logic [1:0]  s_wb_bte = '0;
  logic [3:0]  s_wb_sel = 4'hF;
  logic        s_wb_ack;
  logic [31:0] s_wb_data_o;
  logic        up_rreq;
  logic        up_rack;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata = '0;
  logic        up_wreq;
  logic        up_wack;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;

  up_wishbone_classic dut (
    .clk(clk), .rst(rst),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
    .s_wb_addr(s_wb_addr), .s_wb_data_i(s_wb_data_i),
    .s_wb_cti(s_wb_cti), .s_wb_bte(s_wb_bte), .s_wb_sel(s_wb_sel),
    .s_wb_ack(s_wb_ack), .s_wb_data_o(s_wb_data_o),
    .up_rreq(up_rreq), .up_rack(up_rack), .up_raddr(up_raddr), .up_rdata(up_rdata),
    .up_wreq(up_wreq), .up_wack(up_wack), .up_waddr(up_waddr), .up_wdata(up_wdata)
  );

  always #5 clk = ~clk;

  // uP responder: acks (delay+1) clocks after it first sees a request.
  int   wdelay = 0, rdelay = 0, wcnt = 0, rcnt = 0;
  logic resp_wack = 1'b0, resp_rack = 1'b0;
  logic spur_wack = 1'b0, spur_rack = 1'b0;

  assign up_wack = resp_wack | spur_wack;
  assign up_rack = resp_rack | spur_rack;

  function automatic logic [31:0] rd_model(input logic [13:0] a);
    if (a == 14'd0) return 32'hFEEDBABE;
    if (a == 14'd2) return 32'hB0BDBEEF;
    return 32'hDEADDEAD;
  endfunction

  always @(posedge clk) begin
    resp_wack <= 1'b0;
    resp_rack <= 1'b0;
    up_rdata  <= 32'h0;
    if (up_wreq && !resp_wack) begin
      if (wcnt >= wdelay) begin resp_wack <= 1'b1; wcnt <= 0; end
      else wcnt <= wcnt + 1;
    end else wcnt <= 0;
    if (up_rreq && !resp_rack) begin
      if (rcnt >= rdelay) begin
        resp_rack <= 1'b1; rcnt <= 0; up_rdata <= rd_model(up_raddr);
      end else rcnt <= rcnt + 1;
    end else rcnt <= 0;
  end

  // Monitors sample shortly after each rising edge.
  int          wreq_cnt = 0, rreq_cnt = 0, ack_cnt = 0;
  logic        prev_wreq = 1'b0, prev_rreq = 1'b0;
  logic [13:0] mon_waddr = '0, mon_raddr = '0;
  logic [31:0] mon_wdata = '0;

  always @(posedge clk) begin
    #2;
    if (up_wreq && !prev_wreq) begin
      wreq_cnt++; mon_waddr = up_waddr; mon_wdata = up_wdata;
    end
    if (up_rreq && !prev_rreq) begin
      rreq_cnt++; mon_raddr = up_raddr;
    end
    if (s_wb_ack) ack_cnt++;
    prev_wreq = up_wreq;
    prev_rreq = up_rreq;
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one access starting now (caller is at a negedge); returns at the
  // negedge where ack is seen. With hold=1 cyc/stb stay high for the next access.
  task automatic wb_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                           input bit hold, output logic [31:0] rd, output int lat);
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = we;
    s_wb_addr = addr; s_wb_data_i = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_wb_ack && lat < 200);
    check("ack_timeout", {31'd0, s_wb_ack}, 32'd1);
    rd = s_wb_data_o;
    if (!hold) begin s_wb_cyc = 1'b0; s_wb_stb = 1'b0; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, {31'd0, s_wb_ack}, 32'd0);
    check({tag, "_dout"}, s_wb_data_o, 32'd0);
    check({tag, "_rreq"}, {31'd0, up_rreq}, 32'd0);
    check({tag, "_wreq"}, {31'd0, up_wreq}, 32'd0);
    check({tag, "_raddr"}, {18'd0, up_raddr}, 32'd0);
    check({tag, "_waddr"}, {18'd0, up_waddr}, 32'd0);
    check({tag, "_wdata"}, up_wdata, 32'd0);
  endtask

  logic [31:0] rd;
  int          lat;
  int          base_ack, base_wreq, base_rreq;

  initial begin
    // Reset held 25 clocks.
    repeat (25) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Write sweep: byte addr 4*i -> word addr i.
    for (int i = 0; i < 8; i++) begin
      wb_access(1'b1, 16'(i * 4), 32'hAAAA0000 + 32'(i * 2), 1'b0, rd, lat);
      check("sweep_lat", 32'(lat), 32'd3);
      check("sweep_waddr", {18'd0, mon_waddr}, 32'(i));
      check("sweep_wdata", mon_wdata, 32'hAAAA0000 + 32'(i * 2));
      @(negedge clk);
      check("sweep_wreq_cnt", 32'(wreq_cnt), 32'(i + 1));
      check("sweep_ack_cnt", 32'(ack_cnt), 32'(i + 1));
    end
    check("sweep_no_rreq", 32'(rreq_cnt), 32'd0);
    check("sweep_dout_unchanged", s_wb_data_o, 32'd0);

    // Read decode.
    wb_access(1'b0, 16'h0000, 32'h0, 1'b0, rd, lat);
    check("rd0_data", rd, 32'hFEEDBABE);
    check("rd0_lat", 32'(lat), 32'd3);
    check("rd0_raddr", {18'd0, mon_raddr}, 32'd0);
    @(negedge clk);
    wb_access(1'b0, 16'h0008, 32'h0, 1'b0, rd, lat);
    check("rd8_data", rd, 32'hB0BDBEEF);
    check("rd8_raddr", {18'd0, mon_raddr}, 32'd2);
    @(negedge clk);
    wb_access(1'b0, 16'h000C, 32'h0, 1'b0, rd, lat);
    check("rd12_data", rd, 32'hDEADDEAD);
    check("rd12_raddr", {18'd0, mon_raddr}, 32'd3);
    @(negedge clk);

    // A write leaves the last read data in place.
    wb_access(1'b1, 16'h0010, 32'h01020304, 1'b0, rd, lat);
    check("wr_keeps_dout", rd, 32'hDEADDEAD);
    @(negedge clk);

    // Back-to-back with stb held high; address changes on the ack cycle.
    base_ack = ack_cnt; base_wreq = wreq_cnt; base_rreq = rreq_cnt;
    wb_access(1'b1, 16'h0040, 32'hC0DE0001, 1'b1, rd, lat);
    check("b2b_w0_waddr", {18'd0, mon_waddr}, 32'h10);
    wb_access(1'b0, 16'h0008, 32'h0, 1'b1, rd, lat);
    check("b2b_r_lat", 32'(lat), 32'd4);
    check("b2b_r_data", rd, 32'hB0BDBEEF);
    wb_access(1'b1, 16'h0044, 32'hC0DE0002, 1'b0, rd, lat);
    check("b2b_w1_waddr", {18'd0, mon_waddr}, 32'h11);
    check("b2b_w1_wdata", mon_wdata, 32'hC0DE0002);
    repeat (4) @(negedge clk);
    check("b2b_wreq_cnt", 32'(wreq_cnt - base_wreq), 32'd2);
    check("b2b_rreq_cnt", 32'(rreq_cnt - base_rreq), 32'd1);
    check("b2b_ack_cnt", 32'(ack_cnt - base_ack), 32'd3);

    // Slow write responder; a stray read ack mid-write must be ignored.
    wdelay = 10;
    base_ack = ack_cnt; base_wreq = wreq_cnt;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
    s_wb_addr = 16'h001C; s_wb_data_i = 32'h5A5AA5A5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      spur_rack = (k == 3);
      check("slow_wreq", {31'd0, up_wreq}, 32'd1);
      check("slow_waddr", {18'd0, up_waddr}, 32'd7);
      check("slow_wdata", up_wdata, 32'h5A5AA5A5);
    end
    spur_rack = 1'b0;
    check("slow_no_early_ack", 32'(ack_cnt - base_ack), 32'd0);
    wb_access(1'b1, 16'h001C, 32'h5A5AA5A5, 1'b0, rd, lat);
    repeat (4) @(negedge clk);
    check("slow_ack_cnt", 32'(ack_cnt - base_ack), 32'd1);
    check("slow_wreq_cnt", 32'(wreq_cnt - base_wreq), 32'd1);
    check("slow_dout_kept", s_wb_data_o, 32'hB0BDBEEF);
    wdelay = 0;

    // Acks arriving while idle are ignored.
    base_ack = ack_cnt;
    spur_wack = 1'b1; spur_rack = 1'b1;
    @(negedge clk);
    spur_wack = 1'b0; spur_rack = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ack_ignored", 32'(ack_cnt - base_ack), 32'd0);
    check("idle_dout_kept", s_wb_data_o, 32'hB0BDBEEF);

    // Master abort during READ: uP read completes, no Wishbone ack.
    rdelay = 3;
    base_ack = ack_cnt; base_rreq = rreq_cnt;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b0; s_wb_addr = 16'h0000;
    @(negedge clk);
    check("abort_rreq_up", {31'd0, up_rreq}, 32'd1);
    s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_rreq_done", {31'd0, up_rreq}, 32'd0);
    check("abort_rreq_cnt", 32'(rreq_cnt - base_rreq), 32'd1);
    check("abort_no_ack", 32'(ack_cnt - base_ack), 32'd0);
    rdelay = 0;

    // Reset while in WRITE: everything clears on the next edge, no ack.
    wdelay = 20;
    base_ack = ack_cnt;
    s_wb_cyc = 1'b1; s_wb_stb = 1'b1; s_wb_we = 1'b1;
    s_wb_addr = 16'h0020; s_wb_data_i = 32'h12345678;
    repeat (3) @(negedge clk);
    check("rstw_wreq_up", {31'd0, up_wreq}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_in_write");
    s_wb_cyc = 1'b0; s_wb_stb = 1'b0;
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("rstw_no_ack", 32'(ack_cnt - base_ack), 32'd0);
    wdelay = 0;

    // Bridge is usable again after the mid-transaction reset.
    wb_access(1'b0, 16'h000C, 32'h0, 1'b0, rd, lat);
    check("recover_data", rd, 32'hDEADDEAD);
    check("recover_lat", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/up_wishbone_classic.md
Name: up_wishbone_classic

Overview:
Bridges a Wishbone classic-cycle slave port to the team's simple uP register bus (separate read and write request/acknowledge channels). It sits between a Wishbone master and a peripheral's register decoder. It converts one Wishbone byte-address access into one uP word-address request, waits for the uP acknowledge, then returns the Wishbone ack and, for reads, the read data.

Parameters:
- ADDRESS_WIDTH, 16: Wishbone byte-address width.
- BUS_WIDTH, 4: data bus width in bytes. Data width is BUS_WIDTH*8. Must be a power of two ≥1.
- Derived (localparam): UP_ADDR_WIDTH = ADDRESS_WIDTH - clog2(BUS_WIDTH). This is 14 with the defaults.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- s_wb_cyc  in  1  bus cycle valid.
- s_wb_stb  in  1  strobe.
- s_wb_we  in  1  1 = write, 0 = read.
- s_wb_addr  in  ADDRESS_WIDTH  byte address.
- s_wb_data_i  in  BUS_WIDTH*8  write data.
- s_wb_cti  in  3  cycle type; ignored (classic only).
- s_wb_bte  in  2  burst type; ignored.
- s_wb_sel  in  BUS_WIDTH  byte select; ignored (full-word access always).
- s_wb_ack  out  1  transfer acknowledge, one-cycle pulse.
- s_wb_data_o  out  BUS_WIDTH*8  read data.
- up_rreq  out  1  uP read request.
- up_rack  in  1  uP read acknowledge.
- up_raddr  out  UP_ADDR_WIDTH  uP read word address.
- up_rdata  in  BUS_WIDTH*8  uP read data, valid while up_rack=1.
- up_wreq  out  1  uP write request.
- up_wack  in  1  uP write acknowledge.
- up_waddr  out  UP_ADDR_WIDTH  uP write word address.
- up_wdata  out  BUS_WIDTH*8  uP write data.

Behaviour:
- Reset: the following are all 0 and the FSM is IDLE: s_wb_ack, s_wb_data_o, up_rreq, up_wreq, up_raddr, up_waddr, up_wdata. Reset mid-transaction abandons the transaction; no ack is issued.
- Address mapping: up_addr = s_wb_addr[ADDRESS_WIDTH-1:clog2(BUS_WIDTH)]. For example, byte address 0x000C maps to uP address 3. Low address bits are dropped.
- All outputs are registered.
- FSM has three states: IDLE, WRITE, READ.
- IDLE: on a clock edge where s_wb_cyc & s_wb_stb & ~s_wb_ack:
  - If s_wb_we=1: latch up_waddr and up_wdata, set up_wreq=1, go to WRITE.
  - If s_wb_we=0: latch up_raddr, set up_rreq=1, go to READ.
- WRITE: hold up_wreq, up_waddr and up_wdata stable until up_wack is sampled 1. On that edge, set up_wreq=0, pulse s_wb_ack=1 for one cycle, and return to IDLE.
- READ: hold up_rreq and up_raddr until up_rack is sampled 1. On that edge, capture s_wb_data_o <= up_rdata, set up_rreq=0, pulse s_wb_ack=1, and return to IDLE.
- s_wb_data_o holds the last read value until the next read completes. Writes do not change it.
- Latency: request is asserted 1 clock after the strobe is sampled. s_wb_ack is asserted 1 clock after the ack is sampled. With a registered uP responder, a full access takes 3 clocks, and the next access starts 2 clocks after the ack.
- No re-trigger: a new request is never launched on the edge where s_wb_ack=1. The master may leave stb high continuously and change address/data on the ack edge.
- up_rreq and up_wreq are never high simultaneously. An ack on the non-requested channel, or an ack received in IDLE, is ignored.
- Master abort (cyc or stb drops while in WRITE or READ): the uP request still completes, but s_wb_ack is suppressed on completion.
- uP stall: the request is held indefinitely; there is no timeout.

Decomposition:
- No shared package is needed. FSM state encodings and UP_ADDR_WIDTH are module-local localparams.
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset: hold rst 25 clocks -> all outputs 0, no requests.
- Write sweep: writes to byte addresses 0, 4, …, 28 with data 0xAAAA0000, 0xAAAA0002, …, 0xAAAA000E, and a responder that acks 1 clock after the request. Each write gives up_waddr = 0..7 with matching up_wdata, one up_wreq per access, and one s_wb_ack pulse per access. Exactly 8 acks.
- Read decode: responder returns 0xFEEDBABE at uP addr 0, 0xB0BDBEEF at 2, and 0xDEADDEAD otherwise. Reads at byte address 0 -> s_wb_data_o = 0xFEEDBABE; 8 -> 0xB0BDBEEF; 12 -> 0xDEADDEAD. Ack asserted when each value is valid.
- Back-to-back with stb held high: the address changes on the ack edge -> no duplicate up_rreq/up_wreq for the old address.
- Slow responder: up_wack delayed 10 clocks -> up_wreq, up_waddr and up_wdata stay stable for all 10 clocks, and a single ack follows.
- Abort and reset: drop s_wb_cyc while in READ -> up_rreq completes but no s_wb_ack. Assert rst while in WRITE -> outputs return to 0 on the next edge.
